// File: rtl/shift_seq8_if.sv
// Request, shifter-command and response signals between shift_seq8 and its surroundings.
// master is the sequencer side, slave is the requester/shifter/consumer side.
interface shift_seq8_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_amt;
  logic [7:0] req_data;

  logic [2:0] sh_op;
  logic [1:0] sh_shamt;
  logic [7:0] sh_d_in;
  logic [7:0] sh_d_out;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  modport master (
    input  req_valid, req_op, req_amt, req_data, sh_d_out, rsp_ready,
    output req_ready, sh_op, sh_shamt, sh_d_in, rsp_valid, rsp_data
  );

  modport slave (
    output req_valid, req_op, req_amt, req_data, sh_d_out, rsp_ready,
    input  req_ready, sh_op, sh_shamt, sh_d_in, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_seq8.sv
// Splits a 0..15 shift request into LOAD plus steps of at most 3 for a registered 8-bit shifter.
// Latency 3+ceil(amt/3) cycles from acceptance to rsp_valid; one transaction in flight, rsp held until rsp_ready.
module shift_seq8 (
  input  logic          clk,
  input  logic          reset,
  shift_seq8_if.master  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_LSL  = 2'b00;
  localparam logic [1:0] OP_LSR  = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [2:0] SH_NOP  = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_LSL  = 3'b010;
  localparam logic [2:0] SH_LSR  = 3'b011;
  localparam logic [2:0] SH_ASR  = 3'b100;

  state_t     r_state;
  logic [3:0] r_rem;
  logic [1:0] r_op;
  logic [7:0] r_data;
  logic [7:0] r_rsp_data;
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic [2:0] r_sh_op;
  logic [1:0] r_sh_shamt;

  logic [3:0] w_rem_next;

  function automatic logic [1:0] step_of(input logic [3:0] v);
    return (v > 4'd3) ? 2'd3 : v[1:0];
  endfunction

  function automatic logic [2:0] sh_code(input logic [1:0] op);
    logic [2:0] c;
    case (op)
      OP_LSL:  c = SH_LSL;
      OP_LSR:  c = SH_LSR;
      OP_ASR:  c = SH_ASR;
      default: c = SH_NOP;
    endcase
    return c;
  endfunction

  assign w_rem_next = r_rem - {2'b00, r_sh_shamt};

  // Outputs are registered alongside the state so every output is a pure flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= 4'd0;
      r_op        <= 2'd0;
      r_data      <= 8'h00;
      r_rsp_data  <= 8'h00;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_sh_op     <= SH_NOP;
      r_sh_shamt  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid) begin
            r_op        <= io_bus.req_op;
            r_rem       <= io_bus.req_amt;
            r_data      <= io_bus.req_data;
            r_req_ready <= 1'b0;
            r_sh_op     <= SH_LOAD;
            r_state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (r_op == OP_PASS || r_rem == 4'd0) begin
            r_sh_op <= SH_NOP;
            r_state <= S_WAIT;
          end else begin
            r_sh_op    <= sh_code(r_op);
            r_sh_shamt <= step_of(r_rem);
            r_state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_rem <= w_rem_next;
          if (w_rem_next == 4'd0) begin
            r_sh_op    <= SH_NOP;
            r_sh_shamt <= 2'd0;
            r_state    <= S_WAIT;
          end else begin
            r_sh_shamt <= step_of(w_rem_next);
          end
        end

        // The last shift has just landed in the shifter's output register.
        S_WAIT: begin
          r_rsp_data  <= io_bus.sh_d_out;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end

        S_RESP: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_sh_op     <= SH_NOP;
          r_sh_shamt  <= 2'd0;
        end
      endcase
    end
  end

  assign io_bus.req_ready = r_req_ready;
  assign io_bus.sh_op     = r_sh_op;
  assign io_bus.sh_shamt  = r_sh_shamt;
  assign io_bus.sh_d_in   = r_data;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_shift_seq8.sv
// Bench for shift_seq8: behavioural registered shifter plus a whole-amount golden shift model.
module tb_shift_seq8;

  logic clk = 1'b0;
  logic reset;
  int   cyc_cnt = 0;
  int   n_total = 0;
  int   n_bad = 0;

  logic [7:0] sh_q = 8'h00;
  int   prev_acc;
  int   prev_s;
  bit   have_prev;

  shift_seq8_if bus();

  shift_seq8 dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // External shifter: result registered one clock after the command.
  always @(posedge clk) begin
    case (bus.sh_op)
      3'b001:  sh_q <= bus.sh_d_in;
      3'b010:  sh_q <= sh_q << bus.sh_shamt;
      3'b011:  sh_q <= sh_q >> bus.sh_shamt;
      3'b100:  sh_q <= $signed(sh_q) >>> bus.sh_shamt;
      default: sh_q <= sh_q;
    endcase
  end
  assign bus.sh_d_out = sh_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc_cnt);
    end
  endtask

  function automatic logic [7:0] golden(input logic [1:0] op, input int amt, input logic [7:0] d);
    int v;
    v = d;
    case (op)
      2'd0: return (amt >= 8) ? 8'h00 : 8'((v * (1 << amt)) % 256);
      2'd1: return (amt >= 8) ? 8'h00 : 8'(v / (1 << amt));
      2'd2: begin
        if (d[7]) v = v - 256;
        if (amt >= 8) return d[7] ? 8'hFF : 8'h00;
        // floor division toward -inf for negative values
        if (v < 0) return 8'((v - (1 << amt) + 1) / (1 << amt));
        return 8'(v / (1 << amt));
      end
      default: return d;
    endcase
  endfunction

  function automatic int n_steps(input logic [1:0] op, input int amt);
    return (op == 2'd3) ? 0 : (amt + 2) / 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic [1:0] op, input int amt, input logic [7:0] data,
                        input int hold, input bit gap_chk,
                        input logic [1:0] pop, input int pamt, input logic [7:0] pdata);
    logic [4:0] steps[$];
    logic [4:0] exp_steps[$];
    int  s, n, rem, acc;
    bit  found;
    logic [7:0] exp_res;
    logic [2:0] code;

    s       = n_steps(op, amt);
    exp_res = golden(op, amt, data);
    code    = (op == 2'd0) ? 3'b010 : (op == 2'd1) ? 3'b011 : 3'b100;
    rem     = (op == 2'd3) ? 0 : amt;
    while (rem > 0) begin
      exp_steps.push_back({code, (rem > 3) ? 2'd3 : 2'(rem)});
      rem -= (rem > 3) ? 3 : rem;
    end

    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_amt   = 4'(amt);
    bus.req_data  = data;
    bus.rsp_ready = (hold == 0);
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    acc = cyc_cnt;
    if (gap_chk && have_prev) check("accept_gap", 32'(acc - prev_acc), 32'(prev_s + 4));
    prev_acc  = acc;
    prev_s    = s;
    have_prev = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_amt   = 4'($urandom);
    bus.req_data  = 8'($urandom);

    found = 1'b0;
    n = 1;
    while (!found && n <= 12) begin
      @(negedge clk);
      if (bus.rsp_valid) found = 1'b1;
      else begin
        if (n == 1) begin
          check("load_op", 32'(bus.sh_op), 32'd1);
          check("load_data", 32'(bus.sh_d_in), 32'(data));
        end
        if (bus.sh_op >= 3'b010) steps.push_back({bus.sh_op, bus.sh_shamt});
        tick();
        n++;
      end
    end
    if (!found) begin
      check("rsp_timeout", 32'd0, 32'd1);
      bus.rsp_ready = 1'b1;
      return;
    end
    check("latency", 32'(n), 32'(3 + s));
    check("n_steps", 32'(steps.size()), 32'(exp_steps.size()));
    for (int i = 0; i < steps.size() && i < exp_steps.size(); i++)
      check("step", 32'(steps[i]), 32'(exp_steps[i]));
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_res));

    for (int i = 0; i < hold; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_data", 32'(bus.rsp_data), 32'(exp_res));
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      bus.req_valid = 1'b1;
      bus.req_op    = pop;
      bus.req_amt   = 4'(pamt);
      bus.req_data  = pdata;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_sh_op", 32'(bus.sh_op), 32'd0);
    check("post_rsp_hold", 32'(bus.rsp_data), 32'(exp_res));
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_amt   = 4'd0;
    bus.req_data  = 8'h00;
    bus.rsp_ready = 1'b1;
    have_prev     = 1'b0;
    prev_acc      = 0;
    prev_s        = 0;
    repeat (2) tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_sh_op", 32'(bus.sh_op), 32'd0);
    check("rst_sh_shamt", 32'(bus.sh_shamt), 32'd0);
    check("rst_sh_d_in", 32'(bus.sh_d_in), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    reset = 1'b0;
    tick();

    do_txn(2'd0, 5, 8'h01, 0, 1'b0, 2'd0, 0, 8'h00);
    do_txn(2'd1, 7, 8'h80, 0, 1'b0, 2'd0, 0, 8'h00);
    do_txn(2'd2, 15, 8'h80, 0, 1'b0, 2'd0, 0, 8'h00);
    do_txn(2'd3, 9, 8'hA5, 0, 1'b0, 2'd0, 0, 8'h00);
    do_txn(2'd0, 0, 8'hA5, 0, 1'b0, 2'd0, 0, 8'h00);

    // Backpressure with a new request waiting behind the response.
    do_txn(2'd0, 5, 8'h01, 4, 1'b0, 2'd1, 3, 8'hC3);
    do_txn(2'd1, 3, 8'hC3, 0, 1'b0, 2'd0, 0, 8'h00);

    // Abort in the second shift cycle of an amt=9 LSL.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_amt   = 4'd9;
    bus.req_data  = 8'h5A;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("abort_mid_shift", 32'(bus.sh_op), 32'd2);
    tick();
    reset = 1'b0;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_sh_op", 32'(bus.sh_op), 32'd0);
    do_txn(2'd1, 4, 8'hF0, 0, 1'b0, 2'd0, 0, 8'h00);

    have_prev = 1'b0;
    for (int op = 0; op < 4; op++)
      for (int amt = 0; amt < 16; amt++)
        do_txn(2'(op), amt, 8'($urandom), 0, 1'b1, 2'd0, 0, 8'h00);

    for (int i = 0; i < 12; i++)
      do_txn(2'($urandom_range(0, 3)), $urandom_range(0, 15), 8'($urandom),
             $urandom_range(0, 3), 1'b0, 2'($urandom_range(0, 3)), $urandom_range(0, 15), 8'($urandom));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_seq8.md
Name: shift_seq8

Overview:
- Command-side initiator for the team's registered 8-bit shifter (3-bit op, 2-bit shamt, 8-bit data, result registered one clock after issue).
- Accepts one request per transaction over a valid/ready interface: data, shift kind, and total shift amount 0..15.
- Loads the data into the shifter, then issues a sequence of shift commands of at most 3 positions each.
- Returns the final shifter result on a valid/ready response port. Sits between a control FSM/testbench and one shifter instance.

Parameters:
- None. Widths are fixed: data 8 bits, amount 4 bits, shifter step at most 3.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 PASS (load only).
- req_amt  in  4  total shift amount, 0..15.
- req_data  in  8  operand.
- sh_op  out  3  shifter op: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR.
- sh_shamt  out  2  shifter step amount.
- sh_d_in  out  8  shifter load data.
- sh_d_out  in  8  shifter registered output.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  8  result.

Behaviour:
- One clock (clk); reset is synchronous and active-high. The clock and reset names are fixed as clk and reset.
- On reset (checked at the clk edge):
  - State goes to IDLE.
  - Internal remaining-count, op, and data registers are cleared to 0.
  - rsp_data is set to 0x00.
  - Outputs after reset: req_ready=1, rsp_valid=0, sh_op=000, sh_shamt=00, sh_d_in=0x00.
- All outputs are Moore, decoded from registered state only. There is no combinational path from req_valid or rsp_ready to any output.

States:
- IDLE: req_ready=1, sh_op=NOP.
  - On req_valid&&req_ready, latch op, amt, and data, then go to LOAD.
- LOAD: sh_op=LOAD, sh_d_in=latched data.
  - If op=PASS or amt=0, go to WAIT; otherwise go to SHIFT.
- SHIFT: sh_op is the mapped op (LSL→010, LSR→011, ASR→100); sh_shamt=min(remaining,3).
  - Each cycle, remaining decrements by sh_shamt.
  - When the post-decrement remaining is 0, go to WAIT.
- WAIT: sh_op=NOP.
  - sh_d_out now holds the final result; it is registered into rsp_data at the end of this cycle. Go to RESP.
- RESP: rsp_valid=1, rsp_data stable, sh_op=NOP.
  - On rsp_ready, go to IDLE.
  - rsp_data holds its value after the handshake until the next WAIT.

Timing:
- Number of shift steps S = ceil(amt/3). S=0 for PASS or amt=0, so S ranges 0..5.
- Taking the acceptance cycle as cycle 0: LOAD is in cycle 1, shifts in cycles 2..1+S, WAIT in cycle 2+S, and rsp_valid is first high in cycle 3+S.
- Minimum latency is 3 cycles; maximum is 8.
- Throughput: at most one transaction in flight. req_ready=0 in every state except IDLE, and req_valid is ignored there.
- The earliest next acceptance is the cycle after the rsp handshake.

Arithmetic and boundary rules:
- The shifter does the arithmetic; the sequencer only splits the amount.
- LSL or LSR with amt ≥8 yields 0x00. ASR with amt ≥8 yields 0x00 or 0xFF according to data bit 7.
- Split order is 3,3,…, remainder last. Example: amt 7 → steps 3,3,1.
- rsp_ready held high in cycle 3+S completes the handshake the same cycle, with IDLE in cycle 4+S.
- Reset in any state (including SHIFT and RESP) aborts: IDLE on the next cycle, a pending response is dropped with rsp_valid=0, and no partial shift is resumed.
- The shifter's own register may retain stale data after an abort. This is harmless because every transaction starts with LOAD.
- req_* inputs are sampled only on the acceptance edge. Later changes have no effect on the transaction in flight.

Test Plan:
- LSL, data 0x01, amt 5: steps issued are 010/11 then 010/10; rsp_valid first high in cycle 5 with rsp_data=0x20.
- LSR, data 0x80, amt 7: steps 3,3,1; rsp_valid in cycle 6 with rsp_data=0x01. Separately, ASR, data 0x80, amt 15: five steps (3,3,3,3,3); rsp_valid in cycle 8 with rsp_data=0xFF.
- PASS, data 0xA5, amt 9 (and also LSL with amt 0): no shift commands; rsp_valid in cycle 3 with rsp_data=0xA5.
- Backpressure: hold rsp_ready=0 for 4 cycles while req_valid=1 with a new request.
  - During those cycles: rsp_valid stays 1, rsp_data is stable, req_ready=0, and the new request is not accepted.
  - After rsp_ready=1: IDLE, then the new request is accepted.
- Reset pulse in the second SHIFT cycle of an amt=9 LSL: the next cycle is IDLE with req_ready=1, rsp_valid=0, and sh_op=000. A fresh LSR 0xF0 by 4 then returns 0x0F.
- Back-to-back transactions with rsp_ready tied high: each transaction takes exactly 4+S cycles from one acceptance to the next, and results match a golden shift model for all op/amt combinations over random data.
